// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the multi-channel pulse train generator.
// Holds the per-channel FSM encoding and the default channel/field sizes.
package pulse_gen_pkg;

    localparam int CH_DEFAULT = 4;
    localparam int W_DEFAULT  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } pulse_state_e;

endpackage

// File: rtl/pulse_gen_ch.sv
// One pulse channel: delay, then width/gap alternation, finite or continuous.
// Output and completion strobe are registered from the next state.
import pulse_gen_pkg::*;

module pulse_gen_ch #(
    parameter int W = W_DEFAULT
) (
    input  logic         io_clk,
    input  logic         io_rst,
    input  logic         en,
    input  logic         default_level,
    input  logic [W-1:0] delay_width,
    input  logic [W-1:0] pulse_width,
    input  logic [W-1:0] unaccess_width,
    input  logic [W-1:0] pulse_times,
    output logic         pulse_out,
    output logic         busy,
    output logic         valid
);

    pulse_state_e state_q;
    pulse_state_e state_d;

    logic [W-1:0] dly_q;
    logic [W-1:0] wid_q;
    logic [W-1:0] gap_q;
    logic [W-1:0] times_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] pcnt_q;
    logic [W-1:0] last;
    logic         phase_end;
    logic         last_pulse;
    logic         pulse_d;
    logic         valid_d;

    // cnt_q runs 0..last inside a phase, so a phase lasts last+1 cycles
    always_comb begin
        last = '0;
        unique case (state_q)
            ST_DELAY: last = dly_q - W'(1);
            ST_HIGH:  last = (wid_q == '0) ? '0 : wid_q - W'(1);
            ST_LOW:   last = (gap_q == '0) ? '0 : gap_q - W'(1);
            default:  last = '0;
        endcase
    end

    assign phase_end  = (cnt_q == last);
    assign last_pulse = (times_q != '0) && (pcnt_q == times_q);

    always_ff @(posedge io_clk) begin
        if (!io_rst) begin
            state_q   <= ST_IDLE;
            dly_q     <= '0;
            wid_q     <= '0;
            gap_q     <= '0;
            times_q   <= '0;
            cnt_q     <= '0;
            pcnt_q    <= '0;
            pulse_out <= default_level;
            valid     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pulse_out <= pulse_d;
            valid     <= valid_d;
            if ((state_d != state_q) || !busy) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + W'(1);
            end
            if ((state_q == ST_IDLE) && en) begin
                dly_q   <= delay_width;
                wid_q   <= pulse_width;
                gap_q   <= unaccess_width;
                times_q <= pulse_times;
                pcnt_q  <= (state_d == ST_HIGH) ? W'(1) : '0;
            end else if ((state_q != ST_HIGH) && (state_d == ST_HIGH)) begin
                pcnt_q <= pcnt_q + W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = (delay_width != '0) ? ST_DELAY : ST_HIGH;
                end
            end
            ST_DELAY: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (phase_end) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (phase_end) begin
                    state_d = last_pulse ? ST_DONE : ST_LOW;
                end
            end
            ST_LOW: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (phase_end) begin
                    state_d = ST_HIGH;
                end
            end
            ST_DONE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pulse_d = (state_d == ST_HIGH) ? ~default_level : default_level;
        valid_d = (state_q == ST_HIGH) && (state_d == ST_DONE);
        busy    = (state_q == ST_DELAY) ||
                  (state_q == ST_HIGH)  ||
                  (state_q == ST_LOW);
    end

endmodule

// File: rtl/pulse_train_gen.sv
// Top level: CH independent pulse channels sharing one clock and reset.
// Packed per-channel configuration buses are sliced W bits per channel.
import pulse_gen_pkg::*;

module pulse_train_gen #(
    parameter int CH = CH_DEFAULT,
    parameter int W  = W_DEFAULT
) (
    input  logic            io_clk,
    input  logic            io_rst,
    input  logic [CH-1:0]   io_en,
    input  logic [CH-1:0]   io_defaultLevel,
    input  logic [CH*W-1:0] io_delayWidth,
    input  logic [CH*W-1:0] io_pulseWidth,
    input  logic [CH*W-1:0] io_unaccessWidth,
    input  logic [CH*W-1:0] io_pulse_times,
    output logic [CH-1:0]   io_pulseOut,
    output logic [CH-1:0]   pulse_busy,
    output logic [CH-1:0]   pulse_valid
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pulse_gen_ch #(
            .W(W)
        ) u_ch (
            .io_clk         (io_clk),
            .io_rst         (io_rst),
            .en             (io_en[i]),
            .default_level  (io_defaultLevel[i]),
            .delay_width    (io_delayWidth[i*W +: W]),
            .pulse_width    (io_pulseWidth[i*W +: W]),
            .unaccess_width (io_unaccessWidth[i*W +: W]),
            .pulse_times    (io_pulse_times[i*W +: W]),
            .pulse_out      (io_pulseOut[i]),
            .busy           (pulse_busy[i]),
            .valid          (pulse_valid[i])
        );
    end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter CH, default 4: number of independent pulse channels.
REQ-002 Parameter W, default 32: width of every timing/count field.
REQ-003 io_clk  in  1  single clock; all logic on rising edge.
REQ-004 io_rst  in  1  reset, synchronous, active-low.
REQ-005 io_en  in  CH  per-channel enable; start request and abort.
REQ-006 io_defaultLevel  in  CH  per-channel idle level; active level is its inverse.
REQ-007 io_delayWidth  in  CH*W  per-channel start delay in cycles, channel i at [i*W +: W].
REQ-008 io_pulseWidth  in  CH*W  per-channel active-phase length in cycles.
REQ-009 io_unaccessWidth  in  CH*W  per-channel inactive-phase length in cycles.
REQ-010 io_pulse_times  in  CH*W  per-channel pulse count; 0 selects continuous mode.
REQ-011 io_pulseOut  out  CH  registered pulse outputs.
REQ-012 pulse_busy  out  CH  channel in DELAY, HIGH or LOW.
REQ-013 pulse_valid  out  CH  one-cycle strobe on completion of a finite train.

Function
REQ-014 Each channel SHALL run an independent FSM: IDLE, DELAY, HIGH, LOW, DONE.
REQ-015 IDLE: io_en[i]=1 at an edge SHALL latch delay, width, gap and count, then enter DELAY (delay>0) or HIGH (delay=0).
REQ-016 Config changes after the latch SHALL be ignored until the next start.
REQ-017 Width or gap value 0 SHALL be treated as 1. Every phase lasts max(value,1) cycles.
REQ-018 With delay=0, io_pulseOut[i] SHALL go active on the edge after io_en is sampled high. Delay d adds exactly d cycles.
REQ-019 io_pulseOut[i] SHALL be ~io_defaultLevel[i] in HIGH and io_defaultLevel[i] in every other state.
REQ-020 HIGH->LOW after width cycles; LOW->HIGH after gap cycles. Each HIGH entry SHALL increment a W-bit pulse counter.
REQ-021 Finite mode: when the Nth HIGH ends, the FSM SHALL go to DONE with no trailing LOW. pulse_valid[i]=1 for exactly that one cycle.
REQ-022 Continuous mode (count=0) SHALL never enter DONE or assert pulse_valid. Its pulse counter SHALL wrap silently.
REQ-023 DONE SHALL hold until io_en[i]=0, then go to IDLE. Holding en high SHALL NOT restart the train.
REQ-024 io_en[i]=0 in DELAY/HIGH/LOW SHALL abort to IDLE on the next edge, with output at default level and no pulse_valid.
REQ-025 pulse_busy[i] SHALL be 1 in DELAY, HIGH and LOW only.
REQ-026 Phase counters SHALL be W bits; maximum value 2^W-1 SHALL be honoured exactly, with no overflow.
REQ-027 Channels SHALL NOT interact. Simultaneous starts and aborts on different channels are legal.

Reset
REQ-028 io_rst=0 at an edge SHALL put all FSMs in IDLE, clear all counters, pulse_busy=0 and pulse_valid=0, and load io_pulseOut[i]=io_defaultLevel[i].
REQ-029 Reset SHALL take priority over io_en, including mid-train. No pulse_valid SHALL follow a reset.
REQ-030 After reset release, a channel with io_en already high SHALL start on the first edge where io_rst=1.

Structure
REQ-031 Package pulse_gen_pkg SHALL hold the FSM state enumeration and the CH/W default constants.
REQ-032 Sub-module pulse_gen_ch SHALL implement one channel, with scalar ports and W parameter. The top SHALL generate CH instances and slice the buses.

Verification
REQ-033 ch0 count=10, width=25, gap=15, delay=0, default=0 -> ten 25-cycle highs at 40-cycle period; pulse_valid strobe on the cycle output returns low, 385 cycles after first high.
REQ-034 Same ch0 config, en held high after done, then low for 10 cycles, then count=5, width=25, gap=25 -> no restart while held; second train of 5 pulses at 50-cycle period.
REQ-035 ch1 count=0, width=3, gap=2 for 100 cycles -> period-5 output, busy=1, no pulse_valid; drop en -> output default on next edge, busy=0.
REQ-036 ch0 and ch2 identical config (count=4, width=5, gap=5), ch2 delay=7, started in the same cycle -> ch2 edges exactly 7 cycles later; both strobe valid 7 cycles apart.
REQ-037 ch3 default=1, width=0, gap=0, count=3 -> output 0,1,0,1,0 then 1; valid at the end.
REQ-038 io_rst=0 during the 5th pulse of REQ-033 -> all outputs at default next edge, busy=0, no valid; restart after release reproduces REQ-033 timing.
